// File: rtl/copper_ctrl.sv
// copper_ctrl: raster-synchronised sequencer overriding scroll/ctrl registers per scanline.
// Define COPPER_ADD_EN to make WRITE bit 29 add the value to the target instead of replacing it.
module copper_ctrl #(
  parameter int PROG_AW = 6,
  parameter int CTRL_W  = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ctl_enable,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [31:0]        prog_wrdata,
  input  logic               prog_wren,
  output logic [31:0]        prog_rddata,
  input  logic [8:0]         vline,
  input  logic               vnewframe,
  input  logic [8:0]         base_scroll_x,
  input  logic [7:0]         base_scroll_y,
  input  logic [CTRL_W-1:0]  base_ctrl,
  output logic [8:0]         out_scroll_x,
  output logic [7:0]         out_scroll_y,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               irq,
  output logic               busy,
  output logic [PROG_AW-1:0] pc
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;
  state_t state;
  logic [31:0] mem [2**PROG_AW];
  logic [1:0] ir_op;
  logic [3:0] ir_sel;
  logic [8:0] ir_val;
  logic add;
  logic [8:0] nx;
  logic [7:0] ny;
  logic [CTRL_W-1:0] nc;
  // Nonblocking read beside the CPU write gives read-before-write on collision
  always_ff @(posedge clk) begin
    if (prog_wren) mem[prog_addr] <= prog_wrdata;
    if (state == S_FETCH) begin
      ir_op  <= mem[pc][31:30];
      ir_sel <= mem[pc][27:24];
      ir_val <= mem[pc][8:0];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prog_rddata <= '0;
    else prog_rddata <= mem[prog_addr];
`ifdef COPPER_ADD_EN
  logic ir_add;
  always_ff @(posedge clk)
    if (state == S_FETCH) ir_add <= mem[pc][29];
  assign add = ir_add;
`else
  assign add = 1'b0;
`endif
  assign nx = add ? out_scroll_x + ir_val : ir_val;
  assign ny = add ? out_scroll_y + ir_val[7:0] : ir_val[7:0];
  assign nc = add ? out_ctrl + ir_val[CTRL_W-1:0] : ir_val[CTRL_W-1:0];
  assign busy = state inside {S_FETCH, S_EXEC, S_WAIT};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      irq          <= 1'b0;
      out_scroll_x <= '0;
      out_scroll_y <= '0;
      out_ctrl     <= '0;
    end else begin
      irq <= 1'b0;
      if (!ctl_enable || vnewframe || state == S_IDLE) begin
        out_scroll_x <= base_scroll_x;
        out_scroll_y <= base_scroll_y;
        out_ctrl     <= base_ctrl;
      end
      if (!ctl_enable) state <= S_IDLE;
      else if (vnewframe) begin
        pc    <= '0;
        state <= S_FETCH;
      end else
        case (state)
          S_FETCH: state <= S_EXEC;
          S_EXEC:
            case (ir_op)
              2'b00: state <= S_WAIT;
              2'b01: begin
                if (ir_sel == 4'd0) out_scroll_x <= nx;
                if (ir_sel == 4'd1) out_scroll_y <= ny;
                if (ir_sel == 4'd2) out_ctrl <= nc;
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
              2'b11: begin
                irq   <= 1'b1;
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
              default: state <= S_HALT;
            endcase
          S_WAIT:
            if (ir_val <= 9'd262 && vline >= ir_val) begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          default: state <= state;
        endcase
    end
endmodule
